dot_matrix_frame_scheduler: RTL and testbench
=============================================

// Module: dot_matrix_frame_scheduler
// PURPOSE
//  Double-buffered row-scan scheduler for the 8x8 LED dot matrix.
//  - Producer logic writes a new frame into a back buffer through a valid/ready port.
//  - The block scans the front buffer onto dot_row/dot_col.
//  - Buffers swap only on a frame boundary, so the display never tears.
//  - Sits between pattern/animation logic and the matrix pins; replaces a free-running scan controller.
// PARAMETERS
//  SCAN_DIV  5000  clk cycles per row period, >=2 (must be a multiple of 8 when DIMMING_EN is defined)
//  CNT_W     16    width of scan-tick counter, 2**CNT_W > SCAN_DIV
// PORTS
//  clk          in   1  system clock
//  rst          in   1  asynchronous, active-low reset
//  wr_valid     in   1  back-buffer write request
//  wr_ready     out  1  write accepted when wr_valid & wr_ready at posedge clk
//  wr_row       in   3  row index to write, 0..7
//  wr_data      in   8  column pattern for wr_row; bit 7 = leftmost, 1 = lit
//  swap_req     in   1  1-cycle pulse: publish back buffer at next frame boundary
//  swap_ack     out  1  1-cycle pulse in the cycle the swap takes effect
//  frame_start  out  1  1-cycle pulse when row 0 is driven
//  dot_row      out  8  active-low one-hot row select; row0 = 8'b0111_1111, row7 = 8'b1111_1110
//  dot_col      out  8  active-high column data of the selected row
//  brightness   in   3  present only with DIMMING_EN; 0 = dimmest, 7 = full
// BEHAVIOUR
//  Reset (async, rst=0), all registers cleared:
//  - dot_row = 8'hFF (blank); dot_col = 8'h00.
//  - row_cnt = 0; tick counter = 0; both buffers = 0.
//  - front select = buffer A; state = IDLE; wr_ready = 1; swap_ack = 0; frame_start = 0.
//  Scan timing:
//  - Tick counter counts 0..SCAN_DIV-1 and wraps; tick = (cnt == SCAN_DIV-1).
//  - On tick: dot_row <= ~(8'h80 >> row_cnt); dot_col <= front[row_cnt]; row_cnt <= row_cnt + 1 (3-bit wrap 7->0).
//  - Outputs are registered: new row is visible 1 cycle after the tick cycle.
//  - frame_start pulses in the same cycle that row 0 becomes visible.
//  Write port:
//  - Accepted write: back[wr_row] <= wr_data. The front buffer is never writable.
//  - wr_ready = (state == IDLE).
//  FSM IDLE / PENDING:
//  - IDLE:    swap_req -> PENDING. A write presented in the same cycle as swap_req is still accepted.
//  - PENDING: wr_ready = 0. swap_req is ignored; at most one swap is queued.
//  - PENDING -> IDLE on the tick where row_cnt == 7 (last row of the frame is loaded):
//    - front select toggles in that cycle;
//    - swap_ack = 1 for that cycle;
//    - the next row (row 0) is read from the new front buffer.
//  - The displayed row 7 of the old frame is completed before the swap.
//  - The new back buffer holds the old front contents; it is not cleared.
//  - Reset mid-PENDING: the swap is discarded and both buffers clear to 0.
// CONFIGURATION
//  DIMMING_EN defined:
//  - brightness port exists.
//  - dot_col is forced to 8'h00 while cnt >= (brightness+1)*(SCAN_DIV/8) within each row period.
//  - dot_row is unaffected.
//  - brightness is sampled once per tick; brightness=7 gives full duty.
//  DIMMING_EN undefined:
//  - No brightness port.
//  - dot_col holds row data for the whole row period (full duty).
// TESTING  (SCAN_DIV=8 unless noted)
//  T1 Reset:
//  - rst=0 mid-scan -> dot_row=FF, dot_col=00, wr_ready=1, swap_ack=0 immediately.
//  - After release, the first row appears 9 cycles later as dot_row=7F.
//  T2 Scan order:
//  - Load back = {18,24,42,C3,42,42,42,7E}, then swap.
//  - -> rows 7F,BF,DF,EF,F7,FB,FD,FE with cols 18,24,42,C3,42,42,42,7E.
//  - Each row is held 8 cycles; frame_start pulses on the 7F row.
//  T3 Swap timing:
//  - swap_req while row 3 is displayed.
//  - -> wr_ready=0 until the row-7 tick; swap_ack pulses on that tick.
//  - -> The next row 0 shows the new data, and no old-frame row 0 follows.
//  T4 Back-pressure:
//  - Write issued in PENDING -> not accepted; back buffer unchanged.
//  - Write issued with swap_req in IDLE -> accepted.
//  - Second swap_req in PENDING -> exactly one swap_ack.
//  T5 Wrap/no-tearing:
//  - Rewrite back buffer rows during a displayed frame -> displayed dot_col unchanged until swap_ack.
//  T6 DIMMING_EN (SCAN_DIV=16):
//  - brightness=1 -> dot_col nonzero for 4 of 16 cycles per row.
//  - brightness=7 -> dot_col nonzero for all 16 cycles.

Source files
------------

// File: rtl/dot_matrix_frame_scheduler_if.sv
// Producer write/swap handshake plus matrix pin bundle for the dot-matrix frame scheduler.
// brightness exists only when DIMMING_EN is defined.
interface dot_matrix_frame_scheduler_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [2:0] wr_row;
  logic [7:0] wr_data;
  logic       swap_req;
  logic       swap_ack;
  logic       frame_start;
  logic [7:0] dot_row;
  logic [7:0] dot_col;
`ifdef DIMMING_EN
  logic [2:0] brightness;

  modport master (
    output wr_valid, wr_row, wr_data, swap_req, brightness,
    input  wr_ready, swap_ack, frame_start, dot_row, dot_col
  );
  modport slave (
    input  wr_valid, wr_row, wr_data, swap_req, brightness,
    output wr_ready, swap_ack, frame_start, dot_row, dot_col
  );
`else
  modport master (
    output wr_valid, wr_row, wr_data, swap_req,
    input  wr_ready, swap_ack, frame_start, dot_row, dot_col
  );
  modport slave (
    input  wr_valid, wr_row, wr_data, swap_req,
    output wr_ready, swap_ack, frame_start, dot_row, dot_col
  );
`endif
endinterface

// File: rtl/dot_matrix_frame_scheduler.sv
// Double-buffered 8x8 row scan: rows appear 1 cycle after each scan tick; buffers swap only on the row-7 tick.
// Writes stall (wr_ready=0) while a swap is pending. Define DIMMING_EN for the brightness PWM on dot_col.
module dot_matrix_frame_scheduler #(
  parameter int SCAN_DIV = 5000,
  parameter int CNT_W    = 16
) (
  input logic                         clk,
  input logic                         rst,
  dot_matrix_frame_scheduler_if.slave bus
);
  typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} state_e;

  state_e           state_q, state_d;
  logic             front_sel_q, front_sel_d;  // 0: buffer A is front, 1: buffer B is front
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       row_cnt_q, row_cnt_d;
  logic [7:0]       buf_a_q [8];
  logic [7:0]       buf_b_q [8];
  logic [7:0]       dot_row_q, dot_row_d;
  logic [7:0]       dot_col_q, dot_col_d;
  logic             frame_start_q, frame_start_d;
  logic             tick;
  logic             wr_ready;
  logic             wr_fire;
  logic             swap_ack;
  logic [7:0]       front_row;

  assign tick      = (cnt_q == CNT_W'(SCAN_DIV - 1));
  assign wr_fire   = bus.wr_valid & wr_ready;
  assign front_row = front_sel_q ? buf_b_q[row_cnt_q] : buf_a_q[row_cnt_q];

  always_comb begin
    cnt_d         = tick ? '0 : cnt_q + CNT_W'(1);
    row_cnt_d     = row_cnt_q;
    dot_row_d     = dot_row_q;
    dot_col_d     = dot_col_q;
    frame_start_d = 1'b0;
    if (tick) begin
      row_cnt_d     = row_cnt_q + 3'd1;
      dot_row_d     = ~(8'h80 >> row_cnt_q);
      dot_col_d     = front_row;
      frame_start_d = (row_cnt_q == 3'd0);
    end
  end

  // front_row above still reads the old front on the swap tick, so row 7 finishes the old frame.
  always_comb begin
    state_d     = state_q;
    front_sel_d = front_sel_q;
    wr_ready    = 1'b0;
    swap_ack    = 1'b0;
    case (state_q)
      IDLE: begin
        wr_ready = 1'b1;
        if (bus.swap_req) begin
          state_d = PENDING;
        end
      end
      PENDING: begin
        if (tick && (row_cnt_q == 3'd7)) begin
          state_d     = IDLE;
          front_sel_d = ~front_sel_q;
          swap_ack    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      front_sel_q   <= 1'b0;
      cnt_q         <= '0;
      row_cnt_q     <= 3'd0;
      dot_row_q     <= 8'hFF;
      dot_col_q     <= 8'h00;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      front_sel_q   <= front_sel_d;
      cnt_q         <= cnt_d;
      row_cnt_q     <= row_cnt_d;
      dot_row_q     <= dot_row_d;
      dot_col_q     <= dot_col_d;
      frame_start_q <= frame_start_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) begin
        buf_a_q[i] <= 8'h00;
        buf_b_q[i] <= 8'h00;
      end
    end else if (wr_fire) begin
      if (front_sel_q) begin
        buf_a_q[bus.wr_row] <= bus.wr_data;
      end else begin
        buf_b_q[bus.wr_row] <= bus.wr_data;
      end
    end
  end

  assign bus.wr_ready    = wr_ready;
  assign bus.swap_ack    = swap_ack;
  assign bus.frame_start = frame_start_q;
  assign bus.dot_row     = dot_row_q;

`ifdef DIMMING_EN
  localparam int ROW_SLICE = SCAN_DIV / 8;

  logic [2:0]     bright_q, bright_d;
  logic [CNT_W:0] duty_lim;

  assign bright_d    = tick ? bus.brightness : bright_q;
  assign duty_lim    = (CNT_W + 1)'((int'(bright_q) + 1) * ROW_SLICE);
  // cnt_q restarts at 0 exactly when a new row becomes visible, so it doubles as the PWM phase.
  assign bus.dot_col = ({1'b0, cnt_q} >= duty_lim) ? 8'h00 : dot_col_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bright_q <= 3'd0;
    end else begin
      bright_q <= bright_d;
    end
  end
`else
  assign bus.dot_col = dot_col_q;
`endif
endmodule

// File: tb/tb_dot_matrix_frame_scheduler.sv
// Directed bench for dot_matrix_frame_scheduler with a frame-level reference model checked every cycle.
module tb_dot_matrix_frame_scheduler;
`ifdef DIMMING_EN
  localparam int SD = 16;
`else
  localparam int SD = 8;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  bit   cmp_en = 1'b0;

  dot_matrix_frame_scheduler_if bus();

  dot_matrix_frame_scheduler #(.SCAN_DIV(SD), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: e = clock edges since reset release; tick m lands on edge m*SD and loads row (m-1)%8.
  int         e = 0;
  logic [7:0] mf [8];
  logic [7:0] mb [8];
  bit         pend = 1'b0;
  logic [7:0] m_row = 8'hFF;
  logic [7:0] m_col = 8'h00;
  bit         m_fs = 1'b0;
  logic [2:0] m_bright = 3'd0;

  task automatic model_reset();
    e = 0;
    for (int i = 0; i < 8; i++) begin
      mf[i] = 8'h00;
      mb[i] = 8'h00;
    end
    pend = 1'b0; m_row = 8'hFF; m_col = 8'h00; m_fs = 1'b0; m_bright = 3'd0;
  endtask

  task automatic model_step();
    bit tk;
    bit pend_pre;
    bit swap_now;
    int r;
    logic [7:0] tmp;
    pend_pre = pend;
    tk       = ((e % SD) == SD - 1);
    r        = (e / SD) % 8;
    swap_now = 1'b0;
    m_fs     = 1'b0;
    if (tk) begin
      m_row = ~(8'h80 >> r);
      m_col = mf[r];
      m_fs  = (r == 0);
`ifdef DIMMING_EN
      m_bright = bus.brightness;
`endif
      swap_now = pend_pre && (r == 7);
    end
    if (swap_now) begin
      for (int i = 0; i < 8; i++) begin
        tmp = mf[i]; mf[i] = mb[i]; mb[i] = tmp;
      end
      pend = 1'b0;
    end else if (!pend_pre && bus.swap_req) begin
      pend = 1'b1;
    end
    if (!pend_pre && bus.wr_valid) mb[bus.wr_row] = bus.wr_data;
    e++;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else model_step();
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s timed out", nm);
  endtask

  initial begin
    logic [7:0] exp_col;
    bit         exp_ack;
    forever begin
      @(negedge clk);
      if (rst && cmp_en) begin
        exp_col = m_col;
`ifdef DIMMING_EN
        if ((e % SD) >= (int'(m_bright) + 1) * (SD / 8)) exp_col = 8'h00;
`endif
        exp_ack = pend && ((e % SD) == SD - 1) && (((e / SD) % 8) == 7);
        chk("cmp_dot_row", bus.dot_row, m_row);
        chk("cmp_dot_col", bus.dot_col, exp_col);
        chk("cmp_wr_ready", bus.wr_ready, !pend);
        chk("cmp_swap_ack", bus.swap_ack, exp_ack);
        chk("cmp_frame_start", bus.frame_start, m_fs);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic write_row(input int r, input logic [7:0] d);
    bus.wr_valid = 1'b1;
    bus.wr_row   = r[2:0];
    bus.wr_data  = d;
    cyc();
    bus.wr_valid = 1'b0;
  endtask

  task automatic swap_pulse();
    bus.swap_req = 1'b1;
    cyc();
    bus.swap_req = 1'b0;
  endtask

  task automatic wait_ack(input string nm);
    int n = 0;
    while (bus.swap_ack !== 1'b1 && n < 20 * SD) begin
      cyc();
      n++;
    end
    if (n >= 20 * SD) timeout(nm);
  endtask

  task automatic wait_row(input logic [7:0] r, input string nm);
    int n = 0;
    while (bus.dot_row !== r && n < 20 * SD) begin
      cyc();
      n++;
    end
    if (n >= 20 * SD) timeout(nm);
  endtask

  task automatic wait_row_change(input string nm);
    logic [7:0] prev;
    int n = 0;
    prev = bus.dot_row;
    while (bus.dot_row === prev && n < 4 * SD) begin
      cyc();
      n++;
    end
    if (n >= 4 * SD) timeout(nm);
  endtask

  localparam logic [7:0] ROWS [8] = '{8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE};
  logic [7:0] t2 [8] = '{8'h18, 8'h24, 8'h42, 8'hC3, 8'h42, 8'h42, 8'h42, 8'h7E};
  logic [7:0] t3 [8] = '{8'h81, 8'h42, 8'h24, 8'h18, 8'h18, 8'h24, 8'h42, 8'h81};
  logic [7:0] t4 [8] = '{8'hAA, 8'h24, 8'h42, 8'hC3, 8'h42, 8'h42, 8'h42, 8'h7E};
  logic [7:0] t5 [8] = '{8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h0F};

  // Waits for frame_start, checks all eight rows literally, and confirms the next frame starts 8*SD cycles later.
  task automatic capture_frame(input logic [7:0] cols [8], input string tag);
    int n = 0;
    while (bus.frame_start !== 1'b1 && n < 10 * SD) begin
      cyc();
      n++;
    end
    if (n >= 10 * SD) begin
      timeout({tag, "_frame_start"});
    end else begin
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("%s_row%0d", tag, i), bus.dot_row, ROWS[i]);
        chk($sformatf("%s_col%0d", tag, i), bus.dot_col, cols[i]);
        repeat (SD) cyc();
      end
      chk({tag, "_frame_period"}, bus.frame_start, 1'b1);
    end
  endtask

  initial begin
    int acks;
    int n;
    int lit;
    bus.wr_valid = 1'b0;
    bus.wr_row   = 3'd0;
    bus.wr_data  = 8'h00;
    bus.swap_req = 1'b0;
`ifdef DIMMING_EN
    bus.brightness = 3'd7;
`endif
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b1;
    cmp_en = 1'b1;
    chk("init_wr_ready", bus.wr_ready, 1'b1);
    chk("init_dot_row", bus.dot_row, 8'hFF);

    // T2: load the back buffer, publish it, and scan it.
    for (int i = 0; i < 8; i++) write_row(i, t2[i]);
    swap_pulse();
    wait_ack("t2_ack");
    capture_frame(t2, "t2");

`ifdef DIMMING_EN
    // T6: brightness is sampled at the tick that starts a row and gates dot_col by cycle position.
    bus.brightness = 3'd1;
    wait_row_change("t6_b1_sync");
    wait_row_change("t6_b1_row");
    lit = 0;
    for (int k = 0; k < SD; k++) begin
      if (bus.dot_col != 8'h00) lit++;
      cyc();
    end
    chk("t6_b1_lit_cycles", lit, 4);
    bus.brightness = 3'd7;
    wait_row_change("t6_b7_sync");
    wait_row_change("t6_b7_row");
    lit = 0;
    for (int k = 0; k < SD; k++) begin
      if (bus.dot_col != 8'h00) lit++;
      cyc();
    end
    chk("t6_b7_lit_cycles", lit, 16);
`endif

    // T3: swap requested while row 3 is on the pins.
    for (int i = 0; i < 8; i++) write_row(i, t3[i]);
    wait_row(8'hEF, "t3_row3");
    swap_pulse();
    chk("t3_ready_low", bus.wr_ready, 1'b0);
    wait_ack("t3_ack");
    chk("t3_ack_row6_shown", bus.dot_row, 8'hFD);
    chk("t3_ready_low_at_ack", bus.wr_ready, 1'b0);
    cyc();
    chk("t3_ready_back", bus.wr_ready, 1'b1);
    chk("t3_old_row7", bus.dot_row, 8'hFE);
    chk("t3_old_col7", bus.dot_col, 8'h7E);
    repeat (SD) cyc();
    chk("t3_new_row0", bus.dot_row, 8'h7F);
    chk("t3_new_col0", bus.dot_col, 8'h81);
    chk("t3_new_frame_start", bus.frame_start, 1'b1);

    // T4: write with swap_req is taken; write and second swap_req while pending are dropped.
    bus.wr_valid = 1'b1; bus.wr_row = 3'd0; bus.wr_data = 8'hAA; bus.swap_req = 1'b1;
    cyc();
    chk("t4_pending_ready", bus.wr_ready, 1'b0);
    bus.wr_valid = 1'b1; bus.wr_row = 3'd1; bus.wr_data = 8'h55; bus.swap_req = 1'b1;
    cyc();
    bus.wr_valid = 1'b0; bus.swap_req = 1'b0;
    acks = 0;
    for (int k = 0; k < 24 * SD; k++) begin
      if (bus.swap_ack === 1'b1) acks++;
      cyc();
    end
    chk("t4_single_ack", acks, 1);
    capture_frame(t4, "t4");

    // T5: rewriting the back buffer leaves the displayed frame alone until the swap.
    for (int i = 0; i < 8; i++) write_row(i, t5[i]);
    capture_frame(t4, "t5_hold");
    swap_pulse();
    wait_ack("t5_ack");
    capture_frame(t5, "t5_new");

    // T1: reset in the middle of a pending swap.
    write_row(0, 8'hE7);
    swap_pulse();
    repeat (3) cyc();
    rst = 1'b0;
    #1;
    chk("t1_rst_dot_row", bus.dot_row, 8'hFF);
    chk("t1_rst_dot_col", bus.dot_col, 8'h00);
    chk("t1_rst_wr_ready", bus.wr_ready, 1'b1);
    chk("t1_rst_swap_ack", bus.swap_ack, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    n = 1;
    while (bus.dot_row === 8'hFF && n < 20 * SD) begin
      cyc();
      n++;
    end
    chk("t1_first_row_cycle", n, SD + 1);
    chk("t1_first_row", bus.dot_row, 8'h7F);
    chk("t1_cleared_col", bus.dot_col, 8'h00);
    acks = 0;
    for (int k = 0; k < 9 * SD; k++) begin
      if (bus.swap_ack === 1'b1) acks++;
      cyc();
    end
    chk("t1_swap_discarded", acks, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
